// File: rtl/jpeg_block_scheduler.sv
// Sequences one shared Huffman encoder across the Y/Cb/Cr coefficient buffers of each MCU,
// handshaking buffer ownership and counting MCUs until the frame completes.
module jpeg_block_scheduler #(
  parameter int unsigned  LUMA_BLOCKS     = 4,
  parameter int unsigned  CHROMA_EN       = 1,
  parameter int unsigned  MCU_COUNT_WIDTH = 16,
  localparam int unsigned NUM_SLOTS       = LUMA_BLOCKS + 2 * CHROMA_EN
) (
  input  logic                       clock,
  input  logic                       reset,
  input  logic                       frame_start,
  input  logic [MCU_COUNT_WIDTH-1:0] mcus_per_frame,
  input  logic [NUM_SLOTS-1:0]       buf_ready,
  output logic [NUM_SLOTS-1:0]       buf_release,
  output logic                       huff_start,
  input  logic                       huff_finished,
  output logic [2:0]                 buf_sel,
  output logic [1:0]                 component_id,
  output logic                       dc_pred_clear,
  output logic [MCU_COUNT_WIDTH-1:0] mcu_index,
  output logic                       busy,
  output logic                       frame_done
);

  localparam logic [2:0] LAST_SLOT  = 3'(NUM_SLOTS - 1);
  localparam logic [2:0] LUMA_SLOTS = 3'(LUMA_BLOCKS);

  typedef enum logic [2:0] {
    StIdle,
    StInit,
    StWaitReady,
    StStart,
    StRun,
    StRelease,
    StDone
  } state_e;

  state_e                     r_state;
  logic [2:0]                 r_slot;
  logic [MCU_COUNT_WIDTH-1:0] r_mcu_total;
  logic [MCU_COUNT_WIDTH-1:0] r_mcu_index;
  logic                       r_fin_q;
  logic                       r_last_block;
  logic                       r_huff_start;
  logic                       r_dc_pred_clear;
  logic                       r_frame_done;
  logic                       r_busy;
  logic [NUM_SLOTS-1:0]       r_buf_release;
  logic [2:0]                 r_buf_sel;
  logic [1:0]                 r_component_id;

  logic [NUM_SLOTS-1:0]       w_slot_onehot;
  logic                       w_slot_ready;
  logic                       w_fin_edge;
  logic                       w_slot_wrap;
  logic [2:0]                 w_slot_next;
  logic [MCU_COUNT_WIDTH-1:0] w_mcu_next;
  logic [1:0]                 w_comp;

  always_comb begin
    w_slot_onehot = '0;
    for (int unsigned k = 0; k < NUM_SLOTS; k++) begin
      w_slot_onehot[k] = (r_slot == 3'(k));
    end
  end

  // Only the current slot's ready bit matters; the order is fixed and never skipped.
  assign w_slot_ready = |(buf_ready & w_slot_onehot);
  assign w_fin_edge   = huff_finished & ~r_fin_q;
  assign w_slot_wrap  = (r_slot == LAST_SLOT);
  assign w_slot_next  = w_slot_wrap ? 3'd0 : r_slot + 3'd1;
  assign w_mcu_next   = r_mcu_index + MCU_COUNT_WIDTH'(1);

  always_comb begin
    if (r_slot < LUMA_SLOTS) begin
      w_comp = 2'd0;
    end else if (r_slot == LUMA_SLOTS) begin
      w_comp = 2'd1;
    end else begin
      w_comp = 2'd2;
    end
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      r_state         <= StIdle;
      r_slot          <= '0;
      r_mcu_total     <= '0;
      r_mcu_index     <= '0;
      r_fin_q         <= 1'b0;
      r_last_block    <= 1'b0;
      r_huff_start    <= 1'b0;
      r_dc_pred_clear <= 1'b0;
      r_frame_done    <= 1'b0;
      r_busy          <= 1'b0;
      r_buf_release   <= '0;
      r_buf_sel       <= '0;
      r_component_id  <= '0;
    end else begin
      r_fin_q         <= huff_finished;
      r_huff_start    <= 1'b0;
      r_dc_pred_clear <= 1'b0;
      r_frame_done    <= 1'b0;
      r_buf_release   <= '0;
      unique case (r_state)
        StIdle: begin
          if (frame_start) begin
            r_mcu_total     <= mcus_per_frame;
            r_mcu_index     <= '0;
            r_slot          <= '0;
            r_dc_pred_clear <= 1'b1;
            r_busy          <= 1'b1;
            r_state         <= StInit;
          end
        end
        StInit: begin
          if (r_mcu_total == '0) begin
            r_frame_done <= 1'b1;
            r_state      <= StDone;
          end else begin
            r_buf_sel      <= r_slot;
            r_component_id <= w_comp;
            r_state        <= StWaitReady;
          end
        end
        StWaitReady: begin
          if (w_slot_ready) begin
            r_huff_start <= 1'b1;
            r_state      <= StStart;
          end
        end
        StStart: begin
          // A finished edge in this cycle belongs to the previous block and is ignored.
          r_state <= StRun;
        end
        StRun: begin
          if (w_fin_edge) begin
            r_buf_release <= w_slot_onehot;
            r_slot        <= w_slot_next;
            r_last_block  <= w_slot_wrap && (w_mcu_next == r_mcu_total);
            if (w_slot_wrap) begin
              r_mcu_index <= w_mcu_next;
            end
            r_state <= StRelease;
          end
        end
        StRelease: begin
          // buf_sel/component_id only change here, after the encoder's fetch window closes.
          if (r_last_block) begin
            r_frame_done <= 1'b1;
            r_state      <= StDone;
          end else begin
            r_buf_sel      <= r_slot;
            r_component_id <= w_comp;
            r_state        <= StWaitReady;
          end
        end
        StDone: begin
          r_busy  <= 1'b0;
          r_state <= StIdle;
        end
        default: begin
          r_state <= StIdle;
        end
      endcase
    end
  end

  assign buf_release   = r_buf_release;
  assign huff_start    = r_huff_start;
  assign buf_sel       = r_buf_sel;
  assign component_id  = r_component_id;
  assign dc_pred_clear = r_dc_pred_clear;
  assign mcu_index     = r_mcu_index;
  assign busy          = r_busy;
  assign frame_done    = r_frame_done;

endmodule
